// File: rtl/sd_sector_arbiter_pkg.sv
// sd_sector_arbiter_pkg: op codes, sector size and arbiter state encoding
package sd_sector_arbiter_pkg;
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;
    localparam int SD_SECTOR_BYTES = 512;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, XFER, DONE} arb_state_t;
endpackage

// File: rtl/sd_sector_arbiter_if.sv
// sd_sector_arbiter_if: requester-side and controller-side signals of the sector arbiter
interface sd_sector_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 26
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_op;
    logic [NUM_REQ*ADDR_W-1:0] req_sector;
    logic [NUM_REQ*8-1:0]      req_wdata;
    logic [NUM_REQ-1:0]        grant;
    logic [7:0]                rdata;
    logic [NUM_REQ-1:0]        byte_stb;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ-1:0]        err;
    logic                      sd_execute;
    logic                      sd_op_code;
    logic [ADDR_W-1:0]         sd_sector_address;
    logic [7:0]                sd_outgoing_byte;
    logic [7:0]                sd_incoming_byte;
    logic                      sd_finished_byte;
    logic                      sd_finished_sector;
    logic                      sd_busy;
    modport master (
        input  req, req_op, req_sector, req_wdata,
        input  sd_incoming_byte, sd_finished_byte, sd_finished_sector, sd_busy,
        output grant, rdata, byte_stb, done, err,
        output sd_execute, sd_op_code, sd_sector_address, sd_outgoing_byte
    );
    modport slave (
        output req, req_op, req_sector, req_wdata,
        output sd_incoming_byte, sd_finished_byte, sd_finished_sector, sd_busy,
        input  grant, rdata, byte_stb, done, err,
        input  sd_execute, sd_op_code, sd_sector_address, sd_outgoing_byte
    );
endinterface

// File: rtl/sd_rr_picker.sv
// sd_rr_picker: combinational round-robin pick of the first request at or after ptr
module sd_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic               valid
);
    always_comb begin
        win = '0;
        for (int o = NUM_REQ - 1; o >= 0; o--) begin
            if (req[(int'(ptr) + o) % NUM_REQ]) begin
                win = '0;
                win[(int'(ptr) + o) % NUM_REQ] = 1'b1;
            end
        end
    end
    assign valid = |req;
endmodule

// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter: round-robin sharing of one SD controller between sector requesters
// Define SD_ARB_TIMEOUT_EN to add a watchdog that forces DONE with err after TIMEOUT_CYCLES.
module sd_sector_arbiter
    import sd_sector_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 26,
    parameter int SECTOR_BYTES   = SD_SECTOR_BYTES,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input logic clk,
    input logic rst,
    sd_sector_arbiter_if.master bus
);
    localparam int PTR_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(SECTOR_BYTES) + 1;

    arb_state_t         state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [NUM_REQ-1:0] pick, grant, byte_stb;
    logic               pick_valid, pick_op, op, ovf, tmo, tmo_hit, full;
    logic [ADDR_W-1:0]  pick_sector, sector;
    logic [CNT_W-1:0]   byte_cnt;
    logic [7:0]         wdata_mux, rdata;

    sd_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .req(bus.req), .ptr(ptr), .win(pick), .valid(pick_valid)
    );

    always_comb begin
        pick_op     = |(bus.req_op & pick);
        pick_sector = '0;
        wdata_mux   = '0;
        ptr_nxt     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_sector |= pick[i] ? bus.req_sector[i*ADDR_W +: ADDR_W] : '0;
            wdata_mux   |= grant[i] ? bus.req_wdata[i*8 +: 8] : '0;
            if (grant[i]) ptr_nxt = PTR_W'((i + 1) % NUM_REQ);
        end
    end

    assign full = byte_cnt == CNT_W'(SECTOR_BYTES);

    always_comb begin
        state_nxt = state == IDLE      ? (pick_valid && !bus.sd_busy ? ISSUE : IDLE) :
                    state == ISSUE     ? WAIT_BUSY :
                    state == WAIT_BUSY ? (bus.sd_busy ? XFER : tmo_hit ? DONE : WAIT_BUSY) :
                    state == XFER      ? (bus.sd_finished_sector || tmo_hit ? DONE : XFER) :
                                         IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant    <= '0;
            ptr      <= '0;
            byte_cnt <= '0;
            ovf      <= 1'b0;
            byte_stb <= '0;
            rdata    <= '0;
            op       <= 1'b0;
            sector   <= '0;
        end else begin
            byte_stb <= '0;
            if (state == IDLE && state_nxt == ISSUE) begin
                grant  <= pick;
                op     <= pick_op;
                sector <= pick_sector;
            end
            if (state == ISSUE) begin
                byte_cnt <= '0;
                ovf      <= 1'b0;
            end
            // bytes beyond a full sector are dropped and only flagged
            if (state == XFER && bus.sd_finished_byte) begin
                if (full) ovf <= 1'b1;
                else begin
                    byte_cnt <= byte_cnt + CNT_W'(1);
                    rdata    <= bus.sd_incoming_byte;
                    byte_stb <= grant;
                end
            end
            if (state == DONE) begin
                grant <= '0;
                ptr   <= ptr_nxt;
            end
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
    logic            active;
    assign active  = state == WAIT_BUSY || state == XFER;
    assign tmo_hit = active && wd == WD_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            wd  <= '0;
            tmo <= 1'b0;
        end else begin
            wd  <= active ? wd + WD_W'(1) : '0;
            tmo <= state == ISSUE ? 1'b0 : tmo | tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo     = 1'b0;
`endif

    assign bus.grant             = grant;
    assign bus.byte_stb          = byte_stb;
    assign bus.rdata             = rdata;
    assign bus.done              = state == DONE ? grant : '0;
    assign bus.err               = state == DONE && (!full || ovf || tmo) ? grant : '0;
    assign bus.sd_execute        = state == ISSUE;
    assign bus.sd_op_code        = op;
    assign bus.sd_sector_address = sector;
    assign bus.sd_outgoing_byte  = wdata_mux;
endmodule
